// File: rtl/decode_queue.sv
// Instruction queue plus RV32I decoder feeding a registered dispatch slot.
// Define DECODE_QUEUE_BYPASS_EN to let a fetch skip an empty queue straight into the output register.
module decode_queue #(
    parameter int QUEUE_DEPTH = 8,
    parameter int PTR_WIDTH   = 3,
    localparam int INSIDE_OPCODE_WIDTH = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           in_fetcher_valid,
    input  logic [31:0]                    in_fetcher_instr,
    input  logic [31:0]                    in_fetcher_pc,
    input  logic                           in_fetcher_jump_ce,
    output logic                           out_fetcher_full,
    input  logic                           in_flush,
    output logic                           out_dec_valid,
    input  logic                           in_dec_ready,
    output logic [INSIDE_OPCODE_WIDTH-1:0] out_dec_op,
    output logic [1:0]                     out_dec_unit,
    output logic [4:0]                     out_dec_rd,
    output logic [4:0]                     out_dec_rs1,
    output logic [4:0]                     out_dec_rs2,
    output logic [31:0]                    out_dec_imm,
    output logic [31:0]                    out_dec_pc,
    output logic                           out_dec_jump_ce
);

    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(QUEUE_DEPTH);

    localparam logic [1:0] UNIT_NONE = 2'b00;
    localparam logic [1:0] UNIT_RS   = 2'b01;
    localparam logic [1:0] UNIT_LSB  = 2'b10;

    // Internal opcode numbering; zero is NOP so a cleared register reads as NOP.
    localparam logic [5:0] OP_NOP = 6'd0,  OP_LUI = 6'd1,  OP_AUIPC = 6'd2, OP_JAL = 6'd3,
                           OP_JALR = 6'd4, OP_BEQ = 6'd5,  OP_BNE = 6'd6,  OP_BLT = 6'd7,
                           OP_BGE = 6'd8,  OP_BLTU = 6'd9, OP_BGEU = 6'd10, OP_LB = 6'd11,
                           OP_LH = 6'd12,  OP_LW = 6'd13,  OP_LBU = 6'd14, OP_LHU = 6'd15,
                           OP_SB = 6'd16,  OP_SH = 6'd17,  OP_SW = 6'd18,  OP_ADDI = 6'd19,
                           OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22, OP_ORI = 6'd23,
                           OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI = 6'd26, OP_SRAI = 6'd27,
                           OP_ADD = 6'd28, OP_SUB = 6'd29, OP_SLL = 6'd30, OP_SLT = 6'd31,
                           OP_SLTU = 6'd32, OP_XOR = 6'd33, OP_SRL = 6'd34, OP_SRA = 6'd35,
                           OP_OR = 6'd36,  OP_AND = 6'd37;

    typedef struct packed {
        logic [5:0]  op;
        logic [1:0]  unit;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t        d;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
        f3     = ins[14:12];
        f7     = ins[31:25];
        imm_i  = {{20{ins[31]}}, ins[31:20]};
        imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_u  = {ins[31:12], 12'h000};
        imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm_sh = {27'd0, ins[24:20]};
        d      = '0;
        d.rs1  = ins[19:15];
        d.rs2  = ins[24:20];
        case (ins[6:0])
            7'b0110111: begin d.op = OP_LUI;   d.unit = UNIT_RS; d.rd = ins[11:7]; d.imm = imm_u; end
            7'b0010111: begin d.op = OP_AUIPC; d.unit = UNIT_RS; d.rd = ins[11:7]; d.imm = imm_u; end
            7'b1101111: begin d.op = OP_JAL;   d.unit = UNIT_RS; d.rd = ins[11:7]; d.imm = imm_j; end
            7'b1100111: begin
                d.op = (f3 == 3'b000) ? OP_JALR : OP_NOP;
                d.unit = UNIT_RS; d.rd = ins[11:7]; d.imm = imm_i;
            end
            7'b1100011: begin
                d.unit = UNIT_RS; d.imm = imm_b;
                case (f3)
                    3'b000:  d.op = OP_BEQ;
                    3'b001:  d.op = OP_BNE;
                    3'b100:  d.op = OP_BLT;
                    3'b101:  d.op = OP_BGE;
                    3'b110:  d.op = OP_BLTU;
                    3'b111:  d.op = OP_BGEU;
                    default: d.op = OP_NOP;
                endcase
            end
            7'b0000011: begin
                d.unit = UNIT_LSB; d.rd = ins[11:7]; d.imm = imm_i;
                case (f3)
                    3'b000:  d.op = OP_LB;
                    3'b001:  d.op = OP_LH;
                    3'b010:  d.op = OP_LW;
                    3'b100:  d.op = OP_LBU;
                    3'b101:  d.op = OP_LHU;
                    default: d.op = OP_NOP;
                endcase
            end
            7'b0100011: begin
                d.unit = UNIT_LSB; d.imm = imm_s;
                case (f3)
                    3'b000:  d.op = OP_SB;
                    3'b001:  d.op = OP_SH;
                    3'b010:  d.op = OP_SW;
                    default: d.op = OP_NOP;
                endcase
            end
            7'b0010011: begin
                d.unit = UNIT_RS; d.rd = ins[11:7]; d.imm = imm_i;
                case (f3)
                    3'b000:  d.op = OP_ADDI;
                    3'b010:  d.op = OP_SLTI;
                    3'b011:  d.op = OP_SLTIU;
                    3'b100:  d.op = OP_XORI;
                    3'b110:  d.op = OP_ORI;
                    3'b111:  d.op = OP_ANDI;
                    3'b001:  begin d.op = (f7 == 7'b0000000) ? OP_SLLI : OP_NOP; d.imm = imm_sh; end
                    3'b101:  begin
                        d.imm = imm_sh;
                        d.op  = (f7 == 7'b0000000) ? OP_SRLI :
                                (f7 == 7'b0100000) ? OP_SRAI : OP_NOP;
                    end
                    default: d.op = OP_NOP;
                endcase
            end
            7'b0110011: begin
                d.unit = UNIT_RS; d.rd = ins[11:7];
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d.op = OP_ADD;
                        3'b001:  d.op = OP_SLL;
                        3'b010:  d.op = OP_SLT;
                        3'b011:  d.op = OP_SLTU;
                        3'b100:  d.op = OP_XOR;
                        3'b101:  d.op = OP_SRL;
                        3'b110:  d.op = OP_OR;
                        3'b111:  d.op = OP_AND;
                        default: d.op = OP_NOP;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    d.op = (f3 == 3'b000) ? OP_SUB : (f3 == 3'b101) ? OP_SRA : OP_NOP;
                end else begin
                    d.op = OP_NOP;
                end
            end
            default: d.op = OP_NOP;
        endcase
        // Anything unrecognised collapses to a clean, unit-less NOP.
        if (d.op == OP_NOP) begin
            d = '0;
        end else begin
            d.unit = d.unit;
        end
        return d;
    endfunction

    logic [31:0]        mem_instr_q [QUEUE_DEPTH];
    logic [31:0]        mem_pc_q    [QUEUE_DEPTH];
    logic               mem_jce_q   [QUEUE_DEPTH];
    logic [PTR_WIDTH:0] count_q, count_d;
    logic [PTR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic               full_q, full_d, dec_valid_q, dec_valid_d, dec_jce_q, dec_jce_d;
    dec_t               dec_q, dec_d, dec_s;
    logic [31:0]        dec_pc_q, dec_pc_d, src_instr_s, src_pc_s;
    logic               src_jce_s, accept_s, out_free_s, deq_s, byp_s, enq_s;

    // Queue/output-register control and next-state computation.
    always_comb begin
        accept_s   = rdy && !in_flush && in_fetcher_valid && !full_q;
        out_free_s = !dec_valid_q || in_dec_ready;
        deq_s      = rdy && !in_flush && (count_q != '0) && out_free_s;
`ifdef DECODE_QUEUE_BYPASS_EN
        byp_s       = accept_s && (count_q == '0) && out_free_s;
        src_instr_s = deq_s ? mem_instr_q[head_q] : in_fetcher_instr;
        src_pc_s    = deq_s ? mem_pc_q[head_q]    : in_fetcher_pc;
        src_jce_s   = deq_s ? mem_jce_q[head_q]   : in_fetcher_jump_ce;
`else
        byp_s       = 1'b0;
        src_instr_s = mem_instr_q[head_q];
        src_pc_s    = mem_pc_q[head_q];
        src_jce_s   = mem_jce_q[head_q];
`endif
        enq_s       = accept_s && !byp_s;
        dec_s       = decode(src_instr_s);
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        full_d      = full_q;
        dec_valid_d = dec_valid_q;
        dec_d       = dec_q;
        dec_pc_d    = dec_pc_q;
        dec_jce_d   = dec_jce_q;
        if (in_flush) begin
            count_d     = '0;
            head_d      = '0;
            tail_d      = '0;
            full_d      = 1'b0;
            dec_valid_d = 1'b0;
        end else if (rdy) begin
            count_d = count_q + (PTR_WIDTH + 1)'(enq_s) - (PTR_WIDTH + 1)'(deq_s);
            head_d  = head_q + PTR_WIDTH'(deq_s);
            tail_d  = tail_q + PTR_WIDTH'(enq_s);
            full_d  = (count_d == DEPTH_C);
            if (deq_s || byp_s) begin
                dec_valid_d = 1'b1;
                dec_d       = dec_s;
                dec_pc_d    = src_pc_s;
                dec_jce_d   = src_jce_s;
            end else if (in_dec_ready) begin
                dec_valid_d = 1'b0;
            end else begin
                dec_valid_d = dec_valid_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            full_q      <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_q       <= '0;
            dec_pc_q    <= 32'h0000_0000;
            dec_jce_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            full_q      <= full_d;
            dec_valid_q <= dec_valid_d;
            dec_q       <= dec_d;
            dec_pc_q    <= dec_pc_d;
            dec_jce_q   <= dec_jce_d;
        end
    end

    // Queue storage; contents are meaningless outside head..tail so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_instr_q[tail_q] <= in_fetcher_instr;
            mem_pc_q[tail_q]    <= in_fetcher_pc;
            mem_jce_q[tail_q]   <= in_fetcher_jump_ce;
        end
    end

    assign out_fetcher_full = full_q;
    assign out_dec_valid    = dec_valid_q;
    assign out_dec_op       = dec_q.op;
    assign out_dec_unit     = dec_q.unit;
    assign out_dec_rd       = dec_q.rd;
    assign out_dec_rs1      = dec_q.rs1;
    assign out_dec_rs2      = dec_q.rs2;
    assign out_dec_imm      = dec_q.imm;
    assign out_dec_pc       = dec_pc_q;
    assign out_dec_jump_ce  = dec_jce_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (default build, no bypass).
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst, rdy, in_fetcher_valid, in_fetcher_jump_ce, in_flush, in_dec_ready;
    logic [31:0] in_fetcher_instr, in_fetcher_pc;
    logic        out_fetcher_full, out_dec_valid, out_dec_jump_ce;
    logic [5:0]  out_dec_op;
    logic [1:0]  out_dec_unit;
    logic [4:0]  out_dec_rd, out_dec_rs1, out_dec_rs2;
    logic [31:0] out_dec_imm, out_dec_pc;

    int checks   = 0;
    int failures = 0;

    // Expected internal opcode numbers.
    localparam logic [5:0] E_NOP = 6'd0, E_LUI = 6'd1, E_JAL = 6'd3, E_BEQ = 6'd5,
                           E_LW = 6'd13, E_SW = 6'd18, E_ADDI = 6'd19, E_SRAI = 6'd27;

    typedef struct {
        logic [31:0] ins;
        logic [5:0]  op;
        logic [1:0]  unit;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        c_rs1;
        logic        c_rs2;
    } vec_t;

    vec_t vecs [8];

    decode_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_fetcher_valid(in_fetcher_valid), .in_fetcher_instr(in_fetcher_instr),
        .in_fetcher_pc(in_fetcher_pc), .in_fetcher_jump_ce(in_fetcher_jump_ce),
        .out_fetcher_full(out_fetcher_full), .in_flush(in_flush),
        .out_dec_valid(out_dec_valid), .in_dec_ready(in_dec_ready),
        .out_dec_op(out_dec_op), .out_dec_unit(out_dec_unit), .out_dec_rd(out_dec_rd),
        .out_dec_rs1(out_dec_rs1), .out_dec_rs2(out_dec_rs2), .out_dec_imm(out_dec_imm),
        .out_dec_pc(out_dec_pc), .out_dec_jump_ce(out_dec_jump_ce)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] addi_x1(input int k);
        logic [11:0] imm12;
        imm12 = 12'(k);
        return {imm12, 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic jce);
        in_fetcher_valid   = 1'b1;
        in_fetcher_instr   = ins;
        in_fetcher_pc      = pc;
        in_fetcher_jump_ce = jce;
    endtask

    initial begin
        vecs[0] = '{32'h00500093, E_ADDI, 2'b01, 5'd1, 5'd0, 5'd0, 32'h00000005, 1'b1, 1'b0};
        vecs[1] = '{32'h0020A423, E_SW,   2'b10, 5'd0, 5'd1, 5'd2, 32'h00000008, 1'b1, 1'b1};
        vecs[2] = '{32'hFE000EE3, E_BEQ,  2'b01, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b1};
        vecs[3] = '{32'h4030D093, E_SRAI, 2'b01, 5'd1, 5'd1, 5'd0, 32'h00000003, 1'b1, 1'b0};
        vecs[4] = '{32'h123450B7, E_LUI,  2'b01, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b0};
        vecs[5] = '{32'hFFC12183, E_LW,   2'b10, 5'd3, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b0};
        vecs[6] = '{32'h008000EF, E_JAL,  2'b01, 5'd1, 5'd0, 5'd0, 32'h00000008, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, E_NOP,  2'b00, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0};

        rst = 1'b0; rdy = 1'b1; in_flush = 1'b0; in_dec_ready = 1'b1;
        in_fetcher_valid = 1'b0; in_fetcher_instr = 32'h0; in_fetcher_pc = 32'h0;
        in_fetcher_jump_ce = 1'b0;
        #3;
        chk("rst_valid", 32'(out_dec_valid), 32'h0);
        chk("rst_full", 32'(out_fetcher_full), 32'h0);
        chk("rst_op", 32'(out_dec_op), 32'(E_NOP));
        chk("rst_unit", 32'(out_dec_unit), 32'h0);
        chk("rst_rd", 32'(out_dec_rd), 32'h0);
        chk("rst_imm", out_dec_imm, 32'h0);
        chk("rst_pc", out_dec_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Decode vectors: 2-edge latency, then ready drains the slot.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].ins, 32'h100 + 32'(i * 16), 1'(i));
            step();
            in_fetcher_valid = 1'b0;
            chk("lat_edge1_valid", 32'(out_dec_valid), 32'h0);
            step();
            chk("dec_valid", 32'(out_dec_valid), 32'h1);
            chk("dec_op", 32'(out_dec_op), 32'(vecs[i].op));
            chk("dec_unit", 32'(out_dec_unit), 32'(vecs[i].unit));
            chk("dec_rd", 32'(out_dec_rd), 32'(vecs[i].rd));
            chk("dec_imm", out_dec_imm, vecs[i].imm);
            chk("dec_pc", out_dec_pc, 32'h100 + 32'(i * 16));
            chk("dec_jce", 32'(out_dec_jump_ce), 32'(i % 2));
            if (vecs[i].c_rs1) chk("dec_rs1", 32'(out_dec_rs1), 32'(vecs[i].rs1));
            if (vecs[i].c_rs2) chk("dec_rs2", 32'(out_dec_rs2), 32'(vecs[i].rs2));
            step();
            chk("drain_valid", 32'(out_dec_valid), 32'h0);
        end

        // Backpressure: fill to full with the output held, then drain in order.
        in_dec_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(addi_x1(i), 32'h200 + 32'(i * 4), 1'b0);
            step();
            if (i == 7) chk("full_after7", 32'(out_fetcher_full), 32'h0);
            if (i == 8) chk("full_after9", 32'(out_fetcher_full), 32'h1);
        end
        chk("hold_valid", 32'(out_dec_valid), 32'h1);
        chk("hold_pc", out_dec_pc, 32'h200);
        chk("hold_imm", out_dec_imm, 32'h0);
        chk("hold_full", 32'(out_fetcher_full), 32'h1);
        in_dec_ready = 1'b1;
        step();
        in_fetcher_valid = 1'b0;
        chk("drain_pc1", out_dec_pc, 32'h204);
        chk("drain_full", 32'(out_fetcher_full), 32'h0);
        for (int k = 2; k < 9; k++) begin
            step();
            chk("drain_pc", out_dec_pc, 32'h200 + 32'(k * 4));
            chk("drain_imm", out_dec_imm, 32'(k));
        end
        step();
        chk("drain_end_valid", 32'(out_dec_valid), 32'h0);

        // rdy=0 freezes both the queue and the output register.
        drive(addi_x1(7), 32'h300, 1'b0);
        step();
        in_fetcher_valid = 1'b0;
        rdy = 1'b0;
        step();
        step();
        chk("frz_no_deq", 32'(out_dec_valid), 32'h0);
        rdy = 1'b1;
        step();
        chk("frz_resume_valid", 32'(out_dec_valid), 32'h1);
        chk("frz_resume_pc", out_dec_pc, 32'h300);
        rdy = 1'b0;
        step();
        chk("frz_hold_valid", 32'(out_dec_valid), 32'h1);
        rdy = 1'b1;
        step();
        chk("frz_release", 32'(out_dec_valid), 32'h0);

        // Flush with 1 held + 3 queued and a concurrent fetch.
        in_dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(addi_x1(i), 32'h400 + 32'(i * 4), 1'b0);
            step();
        end
        chk("pre_flush_valid", 32'(out_dec_valid), 32'h1);
        drive(addi_x1(9), 32'h4F0, 1'b0);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        in_fetcher_valid = 1'b0;
        chk("flush_valid", 32'(out_dec_valid), 32'h0);
        chk("flush_full", 32'(out_fetcher_full), 32'h0);
        in_dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_nothing", 32'(out_dec_valid), 32'h0);
        end

        // Asynchronous reset mid-stream.
        in_dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(vecs[1].ins, 32'h500 + 32'(i * 4), 1'b1);
            step();
        end
        in_fetcher_valid = 1'b0;
        chk("pre_arst_valid", 32'(out_dec_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_dec_valid), 32'h0);
        chk("arst_op", 32'(out_dec_op), 32'(E_NOP));
        chk("arst_unit", 32'(out_dec_unit), 32'h0);
        chk("arst_pc", out_dec_pc, 32'h0);
        chk("arst_imm", out_dec_imm, 32'h0);
        chk("arst_rs1", 32'(out_dec_rs1), 32'h0);
        chk("arst_jce", 32'(out_dec_jump_ce), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        in_dec_ready = 1'b1;
        step();
        step();
        chk("arst_discard", 32'(out_dec_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
